// File: rtl/osc_pkg.sv
// Shared oscilloscope ADC constants and sampler FSM state encoding.
// Used by the ADC sampler and downstream waveform buffer logic.
package osc_pkg;

    localparam int ADC_DATA_W     = 8;
    localparam int ADC_SAMPLE_DIV = 100;
    localparam int ADC_CONVST_LO  = 2;
    localparam int ADC_T_CONV     = 42;
    localparam int ADC_RD_LO      = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        WAIT = 3'd2,
        READ = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/osc_tick_div.sv
// Sample-period divider: tick is combinational, high when the counter sits at 0 and en=1.
// Counter wraps at SAMPLE_DIV-1 while enabled and is held at 0 while disabled; no backpressure.
module osc_tick_div #(
    parameter int SAMPLE_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CW'(SAMPLE_DIV - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// Parallel ADC strobe sequencer and capture: sample_valid rises CONVST_LO+T_CONV+RD_LO+1 cycles after a tick.
// A held, unconsumed sample blocks publication; the new sample is dropped and counted in overrun_cnt.
module adc_sampler #(
    parameter int DATA_W     = osc_pkg::ADC_DATA_W,
    parameter int SAMPLE_DIV = osc_pkg::ADC_SAMPLE_DIV,
    parameter int CONVST_LO  = osc_pkg::ADC_CONVST_LO,
    parameter int T_CONV     = osc_pkg::ADC_T_CONV,
    parameter int RD_LO      = osc_pkg::ADC_RD_LO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] db,
    output logic              convstb,
    output logic              csb,
    output logic              rdb,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              trig_pulse,
    output logic [7:0]        overrun_cnt
);

    import osc_pkg::*;

    // Phase counter counts down from (phase length - 1) to 0 in each timed state.
    localparam logic [7:0] CONV_LAST = 8'(CONVST_LO - 1);
    localparam logic [7:0] WAIT_LAST = 8'(T_CONV - 1);
    localparam logic [7:0] RD_LAST   = 8'(RD_LO - 1);

    logic              tick;
    state_e            state_q, state_d;
    logic [7:0]        phase_q, phase_d;
    logic              convstb_q, convstb_d;
    logic              csb_q, csb_d;
    logic              rdb_q, rdb_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              trig_q, trig_d;
    logic [7:0]        ovr_q, ovr_d;
    logic [DATA_W-1:0] prev_q, prev_d;

    osc_tick_div #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        convstb_d = 1'b1;
        csb_d     = 1'b1;
        rdb_d     = 1'b1;
        cap_d     = cap_q;
        data_d    = data_q;
        valid_d   = valid_q;
        trig_d    = trig_q;
        ovr_d     = ovr_q;
        prev_d    = prev_q;

        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
            trig_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d   = CONV;
                    phase_d   = CONV_LAST;
                    convstb_d = 1'b0;
                end
            end
            CONV: begin
                if (phase_q == '0) begin
                    state_d = WAIT;
                    phase_d = WAIT_LAST;
                end else begin
                    phase_d   = phase_q - 8'd1;
                    convstb_d = 1'b0;
                end
            end
            WAIT: begin
                if (phase_q == '0) begin
                    state_d = READ;
                    phase_d = RD_LAST;
                    csb_d   = 1'b0;
                    rdb_d   = 1'b0;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            READ: begin
                if (phase_q == '0) begin
                    state_d = DONE;
                    cap_d   = db;
                end else begin
                    phase_d = phase_q - 8'd1;
                    csb_d   = 1'b0;
                    rdb_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                prev_d  = cap_q;
                if (!valid_q || sample_ready) begin
                    data_d  = cap_q;
                    valid_d = 1'b1;
                    trig_d  = (prev_q < trig_level) && (cap_q >= trig_level);
                end else if (ovr_q != 8'hFF) begin
                    ovr_d = ovr_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            convstb_q <= 1'b1;
            csb_q     <= 1'b1;
            rdb_q     <= 1'b1;
            cap_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            trig_q    <= 1'b0;
            ovr_q     <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            convstb_q <= convstb_d;
            csb_q     <= csb_d;
            rdb_q     <= rdb_d;
            cap_q     <= cap_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            trig_q    <= trig_d;
            ovr_q     <= ovr_d;
            prev_q    <= prev_d;
        end
    end

    assign convstb      = convstb_q;
    assign csb          = csb_q;
    assign rdb          = rdb_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign trig_pulse   = trig_q;
    assign overrun_cnt  = ovr_q;

endmodule
